// File: rtl/key_pkg.sv
// Shared types and constants for the key repeat generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RPT  = 2'd2
    } key_state_t;

    localparam int CNT_W       = 10;
    localparam int PCNT_W      = 8;
    localparam int LONG_MS_DEF = 500;
    localparam int REP_MS_DEF  = 100;

endpackage

// File: rtl/key_hold_timer.sv
// Clearable up-counter with a terminal-match flag for hold/repeat timing.
// Latency: hit is combinational from the registered count.
// Backpressure: none; counts whenever inc is set and clr is not.
//
// Ports:
//   RST  async active-low reset      C1K  clock
//   clr  synchronous clear (wins)    inc  count enable
//   term terminal value to match     hit  count == term
module key_hold_timer
    import key_pkg::*;
(
    input  logic             RST,
    input  logic             C1K,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] term,
    output logic             hit
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge C1K or negedge RST) begin
        if (!RST) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign hit = (cnt == term);

endmodule

// File: rtl/key_repeat_gen.sv
// Key press / long-press / auto-repeat / release pulse generator.
// Latency: PRESS 1 cycle after DET; LONG LONG_MS after PRESS; REP every REP_MS after LONG.
// Backpressure: none; all event outputs are single-cycle registered pulses.
//
// Ports:
//   RST   async active-low reset        C1K   1 kHz clock
//   DET   debounced key-on pulse        BTN   raw button level (1 = pressed)
//   PRESS/LONG/REP/REL  one-cycle event pulses (mutually exclusive)
//   HELD  1 while a press is in progress    PCNT  wrapping count of PRESS pulses
// Build option: define KEY_AUTO_REPEAT_EN to enable REP pulses; otherwise the
// FSM parks in RPT with the counter frozen after LONG and REP stays 0.
module key_repeat_gen
    import key_pkg::*;
#(
    parameter int LONG_MS = LONG_MS_DEF,
    parameter int REP_MS  = REP_MS_DEF
) (
    input  logic              RST,
    input  logic              C1K,
    input  logic              DET,
    input  logic              BTN,
    output logic              PRESS,
    output logic              LONG,
    output logic              REP,
    output logic              REL,
    output logic              HELD,
    output logic [PCNT_W-1:0] PCNT
);

    localparam logic [CNT_W-1:0] LONG_T = CNT_W'(LONG_MS - 1);
    localparam logic [CNT_W-1:0] REP_T  = CNT_W'(REP_MS - 1);

    key_state_t       state, state_nx;
    logic             cnt_clr, cnt_inc, cnt_hit;
    logic [CNT_W-1:0] term;
    logic             press_nx, long_nx, rep_nx, rel_nx;

    // One counter serves both phases; only the terminal value changes.
    assign term = (state == RPT) ? REP_T : LONG_T;

    key_hold_timer u_timer (
        .RST  (RST),
        .C1K  (C1K),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .term (term),
        .hit  (cnt_hit)
    );

    always_ff @(posedge C1K or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            PRESS <= 1'b0;
            LONG  <= 1'b0;
            REP   <= 1'b0;
            REL   <= 1'b0;
            PCNT  <= '0;
        end else begin
            state <= state_nx;
            PRESS <= press_nx;
            LONG  <= long_nx;
            REP   <= rep_nx;
            REL   <= rel_nx;
            PCNT  <= PCNT + PCNT_W'(press_nx);
        end
    end

    // Release is tested before the terminal match so it wins a collision.
    always_comb begin
        state_nx = state;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        press_nx = 1'b0;
        long_nx  = 1'b0;
        rep_nx   = 1'b0;
        rel_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (DET) begin
                    state_nx = HOLD;
                    cnt_clr  = 1'b1;
                    press_nx = 1'b1;
                end
            end
            HOLD: begin
                if (!BTN) begin
                    state_nx = IDLE;
                    cnt_clr  = 1'b1;
                    rel_nx   = 1'b1;
                end else if (cnt_hit) begin
                    state_nx = RPT;
                    cnt_clr  = 1'b1;
                    long_nx  = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            RPT: begin
                if (!BTN) begin
                    state_nx = IDLE;
                    cnt_clr  = 1'b1;
                    rel_nx   = 1'b1;
                end else begin
`ifdef KEY_AUTO_REPEAT_EN
                    if (cnt_hit) begin
                        cnt_clr = 1'b1;
                        rep_nx  = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
`else
                    // Parked after LONG: counter frozen, no repeats.
                    cnt_inc = 1'b0;
`endif
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_clr  = 1'b1;
            end
        endcase
    end

    assign HELD = (state != IDLE);

endmodule

// File: tb/tb_key_repeat_gen.sv
module tb_key_repeat_gen;

    localparam int LONG_MS = 500;
    localparam int REP_MS  = 100;
`ifdef KEY_AUTO_REPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       RST, C1K, DET, BTN;
    logic       PRESS, LONG, REP, REL, HELD;
    logic [7:0] PCNT;

    key_repeat_gen #(.LONG_MS(LONG_MS), .REP_MS(REP_MS)) dut (
        .RST   (RST),
        .C1K   (C1K),
        .DET   (DET),
        .BTN   (BTN),
        .PRESS (PRESS),
        .LONG  (LONG),
        .REP   (REP),
        .REL   (REL),
        .HELD  (HELD),
        .PCNT  (PCNT)
    );

    initial C1K = 1'b0;
    always #5 C1K = ~C1K;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // Reference model: timestamps of the press and of the last LONG/REP event.
    int t = 0;
    bit m_act, m_long;
    int m_ps, m_mark, m_pcnt;

    task automatic model_reset();
        m_act = 0; m_long = 0; m_ps = 0; m_mark = 0; m_pcnt = 0;
    endtask

    // Observed event log for directed timing checks.
    int press_at, long_at, rel_at, press_cnt, long_cnt, rel_cnt;
    int rep_q[$];

    task automatic clr_rec();
        press_at = -1; long_at = -1; rel_at = -1;
        press_cnt = 0; long_cnt = 0; rel_cnt = 0;
        rep_q.delete();
    endtask

    function automatic logic [31:0] outs();
        return 32'({PRESS, LONG, REP, REL, HELD, PCNT});
    endfunction

    task automatic step();
        bit e_p, e_l, e_r, e_rel;
        @(posedge C1K);
        #1;
        t++;
        e_p = 0; e_l = 0; e_r = 0; e_rel = 0;
        if (!RST) begin
            model_reset();
        end else if (!m_act) begin
            if (DET) begin
                m_act = 1; m_long = 0; m_ps = t; e_p = 1;
                m_pcnt = (m_pcnt + 1) % 256;
            end
        end else if (!BTN) begin
            m_act = 0; e_rel = 1;
        end else if (!m_long) begin
            if (t - m_ps == LONG_MS) begin
                m_long = 1; m_mark = t; e_l = 1;
            end
        end else if (AUTO && (t - m_mark == REP_MS)) begin
            m_mark = t; e_r = 1;
        end
        chk("cycle", outs(), 32'({e_p, e_l, e_r, e_rel, m_act, 8'(m_pcnt)}));
        if (PRESS) begin press_at = t; press_cnt++; end
        if (LONG)  begin long_at = t;  long_cnt++;  end
        if (REP)   rep_q.push_back(t);
        if (REL)   begin rel_at = t;   rel_cnt++;   end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            DET = 1'b0;
            BTN = 1'($urandom_range(0, 1));
            step();
        end
        BTN = 1'b0;
    endtask

    // DET in cycle 0, BTN high cycles 0..n, low in cycle n+1 -> REL at n+2.
    task automatic press_hold(input int n, input bit stray);
        DET = 1'b1; BTN = 1'b1;
        step();
        for (int i = 0; i < n; i++) begin
            DET = stray && ($urandom_range(0, 9) == 0);
            step();
        end
        DET = 1'b0; BTN = 1'b0;
        step();
    endtask

    int t0, p0, nrep;

    initial begin
        RST = 1'b0; DET = 1'b0; BTN = 1'b0;
        model_reset();
        clr_rec();
        #12;
        chk("rst_state", outs(), 32'h0);
        step(); step();
        #2 RST = 1'b1;
        idle(3);

        // Short press
        clr_rec(); t0 = t;
        press_hold(20, 0);
        idle(2);
        chk("short_press_at", 32'(press_at - t0), 32'd1);
        chk("short_rel_at", 32'(rel_at - t0), 32'd22);
        chk("short_nlong", 32'(long_cnt), 32'd0);
        chk("short_pcnt", 32'(PCNT), 32'd1);

        // Long press with repeats
        clr_rec(); t0 = t;
        press_hold(800, 0);
        idle(2);
        chk("long_press_at", 32'(press_at - t0), 32'd1);
        chk("long_long_at", 32'(long_at - t0), 32'd501);
        nrep = AUTO ? 3 : 0;
        chk("long_nrep", 32'(rep_q.size()), 32'(nrep));
        for (int i = 0; i < rep_q.size(); i++)
            chk("long_rep_at", 32'(rep_q[i] - t0), 32'(501 + 100 * (i + 1)));
        chk("long_rel_at", 32'(rel_at - t0), 32'd802);

        // Release in the same sample as the LONG terminal
        clr_rec(); t0 = t;
        press_hold(LONG_MS - 1, 0);
        idle(2);
        chk("coll_rel_at", 32'(rel_at - t0), 32'd501);
        chk("coll_nlong", 32'(long_cnt), 32'd0);

        // DET with BTN low in IDLE: accepted, REL next edge
        clr_rec(); t0 = t;
        DET = 1'b1; BTN = 1'b0; step();
        DET = 1'b0; step();
        idle(1);
        chk("detlow_rel_at", 32'(rel_at - t0), 32'd2);

        // Stray DET pulses during HOLD
        clr_rec(); p0 = int'(PCNT);
        DET = 1'b1; BTN = 1'b1; step();
        for (int i = 0; i < 50; i++) begin
            DET = (i % 7 == 3);
            step();
        end
        DET = 1'b0; BTN = 1'b0; step();
        idle(1);
        chk("stray_npress", 32'(press_cnt), 32'd1);
        chk("stray_pcnt", 32'(PCNT), 32'((p0 + 1) % 256));

        // Randomized presses around the interesting boundaries
        for (int it = 0; it < 40; it++) begin
            int kind, n;
            idle($urandom_range(0, 4));
            kind = $urandom_range(0, 3);
            case (kind)
                0: n = $urandom_range(0, 30);
                1: n = LONG_MS - 3 + $urandom_range(0, 5);
                2: n = $urandom_range(0, 900);
                default: n = LONG_MS + REP_MS - 3 + $urandom_range(0, 5);
            endcase
            press_hold(n, 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of RPT: asynchronous clear, no REL afterwards
        idle(1);
        DET = 1'b1; BTN = 1'b1; step();
        DET = 1'b0;
        for (int i = 0; i < 550; i++) step();
        #3 RST = 1'b0;
        model_reset();
        #1;
        chk("async_rst", outs(), 32'h0);
        clr_rec();
        step(); step(); step();
        #2 RST = 1'b1;
        step(); step(); step();
        chk("rst_norel", 32'(rel_cnt), 32'd0);
        BTN = 1'b0;
        press_hold(5, 0);
        chk("rst_pcnt", 32'(PCNT), 32'd1);

        // PCNT wrap: 255 more presses bring it back to 0
        for (int i = 0; i < 255; i++) press_hold(0, 0);
        idle(1);
        chk("wrap_pcnt", 32'(PCNT), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
